bcd_scan_ctrl: RTL

//  Shares one bcd_decimal converter among NUM_CH 4-bit channels: on Load, snapshots all

---
 rtl/bcd_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_scan_ctrl
//
// Purpose:
//   Converts NUM_CH 4-bit channel values into tens/ones decimal digits using a
//   single shared converter, one channel per clock, and commits the finished
//   digit set atomically. Independently scans the committed digits onto one
//   digit bus with a one-hot position select for a multiplexed 7-segment
//   display.
//
// Parameters:
//   NUM_CH       number of 4-bit input channels (1..8)
//   REFRESH_DIV  clock cycles spent on each display position (>= 2)
//
// Ports:
//   Clock    in   system clock, rising edge
//   Resetn   in   synchronous active-low reset
//   Load     in   conversion request, honoured only while idle
//   V_all    in   channel values, channel k = V_all[4k+3:4k]
//   Busy     out  snapshot held / conversion in progress
//   Done     out  one-cycle pulse when a new digit set is committed
//   D1       out  committed tens digit per channel (0 or 1)
//   D0       out  committed ones digit per channel (0..9)
//   Sel      out  one-hot display position (bit 2k = ch k ones, 2k+1 = tens)
//   Digit    out  value for the selected position
//   Blank    out  selected position should be blanked
//
// Build option:
//   BCD_BLANK_LEADING_EN  when defined, Blank is raised on a tens position whose
//                         tens digit is 0 (leading-zero suppression). When not
//                         defined, Blank is constant 0.
// -----------------------------------------------------------------------------
module bcd_scan_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Load,
  input  logic [4*NUM_CH-1:0]   V_all,
  output logic                  Busy,
  output logic                  Done,
  output logic [NUM_CH-1:0]     D1,
  output logic [4*NUM_CH-1:0]   D0,
  output logic [2*NUM_CH-1:0]   Sel,
  output logic [3:0]            Digit,
  output logic                  Blank
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int POS_W = $clog2(2 * NUM_CH);
  localparam int DIV_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic capture_en;
  logic conv_en;
  logic commit_en;
  logic busy_next;

  logic [4*NUM_CH-1:0] snap_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [NUM_CH-1:0]   tens_shadow_reg;
  logic [4*NUM_CH-1:0] ones_shadow_reg;
  logic [NUM_CH-1:0]   d1_reg;
  logic [4*NUM_CH-1:0] d0_reg;
  logic                done_reg;

  logic [3:0] conv_val;
  logic       conv_tens;
  logic [3:0] conv_ones;

  // ---------------------------------------------------------------------------
  // Conversion FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (Load) state_next = ST_CONV;
      ST_CONV:   if (idx_reg == IDX_W'(NUM_CH - 1)) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    capture_en = 1'b0;
    conv_en    = 1'b0;
    commit_en  = 1'b0;
    busy_next  = 1'b0;
    case (state_reg)
      ST_IDLE:   capture_en = Load;
      ST_CONV:   begin conv_en   = 1'b1; busy_next = 1'b1; end
      ST_COMMIT: begin commit_en = 1'b1; busy_next = 1'b1; end
      default:   ;
    endcase
  end

  assign Busy = busy_next;

  // ---------------------------------------------------------------------------
  // Shared converter: selects the snapshot channel addressed by idx_reg.
  // ---------------------------------------------------------------------------
  always_comb begin
    conv_val = 4'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_reg == IDX_W'(i)) conv_val = snap_reg[4*i +: 4];
    end
  end

  assign conv_tens = (conv_val > 4'd9);
  assign conv_ones = conv_tens ? (conv_val - 4'd10) : conv_val;

  // ---------------------------------------------------------------------------
  // Snapshot, channel index, shadow digits and committed digits
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      snap_reg        <= '0;
      idx_reg         <= '0;
      tens_shadow_reg <= '0;
      ones_shadow_reg <= '0;
      d1_reg          <= '0;
      d0_reg          <= '0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= commit_en;
      if (capture_en) begin
        snap_reg <= V_all;
        idx_reg  <= '0;
      end
      if (conv_en) begin
        idx_reg <= idx_reg + 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (idx_reg == IDX_W'(i)) begin
            tens_shadow_reg[i]       <= conv_tens;
            ones_shadow_reg[4*i +: 4] <= conv_ones;
          end
        end
      end
      // Whole set moves at once so the outputs never show a mixed set.
      if (commit_en) begin
        d1_reg <= tens_shadow_reg;
        d0_reg <= ones_shadow_reg;
      end
    end
  end

  assign D1   = d1_reg;
  assign D0   = d0_reg;
  assign Done = done_reg;

  // ---------------------------------------------------------------------------
  // Display scan: free-running, independent of the conversion FSM
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]    div_reg;
  logic [DIV_W-1:0]    div_next;
  logic                div_wrap;
  logic [POS_W-1:0]    pos_reg;
  logic [POS_W-1:0]    pos_next;
  logic [2*NUM_CH-1:0] sel_reg;
  logic [2*NUM_CH-1:0] sel_next;
  logic [3:0]          digit_reg;
  logic [3:0]          digit_next;

  assign div_wrap = (div_reg == DIV_W'(REFRESH_DIV - 1));
  assign div_next = div_wrap ? '0 : (div_reg + 1'b1);

  always_comb begin
    pos_next = pos_reg;
    if (div_wrap) begin
      pos_next = (pos_reg == POS_W'(2*NUM_CH - 1)) ? '0 : (pos_reg + 1'b1);
    end
  end

  // Sel, Digit and Blank are all derived from pos_next so they register on
  // the same edge and stay aligned with each other.
  genvar gi;
  generate
    for (gi = 0; gi < 2*NUM_CH; gi++) begin : g_sel
      assign sel_next[gi] = (pos_next == POS_W'(gi));
    end
  endgenerate

  always_comb begin
    digit_next = 4'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pos_next == POS_W'(2*i))     digit_next = d0_reg[4*i +: 4];
      if (pos_next == POS_W'(2*i + 1)) digit_next = {3'b000, d1_reg[i]};
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      div_reg   <= '0;
      pos_reg   <= '0;
      sel_reg   <= (2*NUM_CH)'(1);
      digit_reg <= 4'd0;
    end else begin
      div_reg   <= div_next;
      pos_reg   <= pos_next;
      sel_reg   <= sel_next;
      digit_reg <= digit_next;
    end
  end

  assign Sel   = sel_reg;
  assign Digit = digit_reg;

`ifdef BCD_BLANK_LEADING_EN
  logic blank_next;
  logic blank_reg;

  // Only tens positions can be suppressed; ones digits are always shown.
  always_comb begin
    blank_next = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pos_next == POS_W'(2*i + 1)) blank_next = ~d1_reg[i];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      blank_reg <= 1'b0;
    end else begin
      blank_reg <= blank_next;
    end
  end

  assign Blank = blank_reg;
`else
  assign Blank = 1'b0;
`endif

endmodule
